// File: rtl/hydro_window_ctrl_pkg.sv
// Shared types and helpers for the hydrophone window scheduler.
package hydro_pkg;

  localparam int CHANNELS = 4;
  localparam int SAMPLE_W = 16;
  localparam int ERR_W    = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [SAMPLE_W-1:0] mag_t;

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} win_state_e;

  // The most negative sample has no positive twin, so it clips to full scale.
  function automatic mag_t abs_sat(input sample_t s);
    mag_t m;
    if (s == sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}}))
      m = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (s[SAMPLE_W-1])
      m = mag_t'(-s);
    else
      m = mag_t'(s);
    return m;
  endfunction

endpackage

// File: rtl/hydro_window_ctrl_if.sv
// 32-bit AXI-Stream link carrying two 16-bit hydrophone channels per beat.
interface hydro_window_ctrl_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/hydro_window_ctrl_peak_track.sv
// Per-channel peak-magnitude tracker; frame index of the peak is kept only
// when HYDRO_ARGMAX_EN is defined.
module peak_track
  import hydro_pkg::*;
`ifdef HYDRO_ARGMAX_EN
  #(parameter int FCW = 1)
`endif
  (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clr,
    input  logic           upd,
    input  sample_t        sample,
`ifdef HYDRO_ARGMAX_EN
    input  logic [FCW-1:0] frame_idx,
    output logic [FCW-1:0] idx,
`endif
    output mag_t           peak
  );

  mag_t mag;
  logic take;

  assign mag  = abs_sat(sample);
  // Strict compare so a tie keeps the earliest frame.
  assign take = upd && (mag > peak);

  always_ff @(posedge clk) begin
    if (!resetn)   peak <= '0;
    else if (clr)  peak <= '0;
    else if (take) peak <= mag;
  end

`ifdef HYDRO_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (!resetn)   idx <= '0;
    else if (clr)  idx <= '0;
    else if (take) idx <= frame_idx;
  end
`endif

endmodule

// File: rtl/hydro_window_ctrl.sv
// Frame-aligned window scheduler with per-channel peak tracking.
// Optional per-peak frame index: define HYDRO_ARGMAX_EN.
module hydro_window_ctrl
  import hydro_pkg::*;
  #(
    parameter  int WINDOW_FRAMES = 250000,
    localparam int FCW           = $clog2(WINDOW_FRAMES)
  ) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    hydro_window_ctrl_if.slave      s_axis,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CHANNELS*SAMPLE_W-1:0] res_peak,
    output logic [CHANNELS*FCW-1:0] res_idx,
    output logic [ERR_W-1:0]        frame_err_cnt,
    output logic                    busy
  );

  win_state_e     state, state_nx;
  logic           beat_ptr, beat_ptr_nx;
  logic [FCW-1:0] frame_cnt, frame_cnt_nx;
  logic           acc, clr, upd_lo, upd_hi, err;

  assign s_axis.tready = (state != DONE);
  assign acc           = s_axis.tvalid && s_axis.tready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      beat_ptr      <= 1'b0;
      frame_cnt     <= '0;
      res_valid     <= 1'b0;
      busy          <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      state     <= state_nx;
      beat_ptr  <= beat_ptr_nx;
      frame_cnt <= frame_cnt_nx;
      res_valid <= (state_nx == DONE);
      busy      <= (state_nx == RUN);
      if (err && (frame_err_cnt != '1))
        frame_err_cnt <= frame_err_cnt + ERR_W'(1);
    end
  end

  // en low always wins; a framing error on a tlast beat restarts in place.
  always_comb begin
    state_nx     = state;
    beat_ptr_nx  = beat_ptr;
    frame_cnt_nx = frame_cnt;
    clr          = 1'b0;
    upd_lo       = 1'b0;
    upd_hi       = 1'b0;
    err          = 1'b0;
    unique case (state)
      IDLE: if (en) state_nx = SYNC;
      SYNC: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (acc && s_axis.tlast) begin
          state_nx     = RUN;
          beat_ptr_nx  = 1'b0;
          frame_cnt_nx = '0;
          clr          = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (acc) begin
          if (!beat_ptr) begin
            if (!s_axis.tlast) begin
              upd_lo      = 1'b1;
              beat_ptr_nx = 1'b1;
            end else begin
              err          = 1'b1;
              clr          = 1'b1;
              frame_cnt_nx = '0;
            end
          end else begin
            beat_ptr_nx = 1'b0;
            if (s_axis.tlast) begin
              upd_hi = 1'b1;
              if (frame_cnt == FCW'(WINDOW_FRAMES - 1)) begin
                state_nx     = DONE;
                frame_cnt_nx = '0;
              end else begin
                frame_cnt_nx = frame_cnt + FCW'(1);
              end
            end else begin
              err      = 1'b1;
              state_nx = SYNC;
            end
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nx     = en ? RUN : IDLE;
          clr          = 1'b1;
          beat_ptr_nx  = 1'b0;
          frame_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int LANE = c % 2;
    logic upd_c;
    assign upd_c = (c < 2) ? upd_lo : upd_hi;

    peak_track
`ifdef HYDRO_ARGMAX_EN
      #(.FCW(FCW))
`endif
      u_peak (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (clr),
        .upd       (upd_c),
        .sample    (sample_t'(s_axis.tdata[LANE*SAMPLE_W +: SAMPLE_W])),
`ifdef HYDRO_ARGMAX_EN
        .frame_idx (frame_cnt),
        .idx       (res_idx[c*FCW +: FCW]),
`endif
        .peak      (res_peak[c*SAMPLE_W +: SAMPLE_W])
      );
  end

`ifndef HYDRO_ARGMAX_EN
  assign res_idx = '0;
`endif

endmodule

// File: doc/hydro_window_ctrl.md
# hydro_window_ctrl

Window scheduler for the 4‑channel hydrophone sample stream. Accepts the 2‑beat AXI‑Stream frame (beat0 = ch0/ch1, beat1 = ch2/ch3 with tlast), aligns to frame boundaries, and sequences fixed-length sampling windows. Within each window it tracks per-channel peak magnitude and its frame index. At window end it hands the result to a downstream consumer via valid/ready.

## Interface
- WINDOW_FRAMES, 250000, frames per window (= 500000 beats); legal ≥ 2
- FCW, $clog2(WINDOW_FRAMES), frame-index width (derived, not overridden)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- en  in  1  run enable
- s_axis_tdata  in  32  [15:0] low channel, [31:16] high channel; signed two's complement
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  frame end (beat1)
- s_axis_tready  out  1  stream ready
- res_valid  out  1  window result valid
- res_ready  in  1  consumer ready
- res_peak  out  64  4×16 unsigned peak magnitude; ch0 at [15:0], ch3 at [63:48]
- res_idx  out  4×FCW  frame index of each peak; ch0 in the LSBs
- frame_err_cnt  out  8  framing-error count, saturating
- busy  out  1  state == RUN

## Operation
- States: IDLE, SYNC, RUN, DONE. Reset → IDLE.
- A beat is accepted when tvalid & tready.
- s_axis_tready = (state != DONE). Beats in IDLE/SYNC are accepted and discarded.
- IDLE: en=1 → SYNC.
- SYNC: en=0 → IDLE. An accepted beat with tlast → RUN; beat pointer = beat0, frame counter = 0, accumulators cleared.
- RUN, beat0 expected:
  - tlast=0 → update ch0/ch1.
  - tlast=1 → framing error.
- RUN, beat1 expected:
  - tlast=1 → update ch2/ch3, frame counter +1.
  - tlast=0 → framing error.
- Frame counter reaching WINDOW_FRAMES → DONE, with the final beat's values included.
- Framing error:
  - frame_err_cnt +1, saturating at 255.
  - Window aborted; no result is produced.
  - If the offending beat carries tlast, go straight to RUN with a fresh window. Otherwise go to SYNC.
- Magnitude = |sample|; −32768 saturates to 32767.
- Update rule: replace the peak only if mag > stored peak (strict). Ties keep the earliest frame. Index = current frame counter.
- Accumulators clear to peak 0, idx 0 at every window start.
- DONE: res_valid=1; res_peak and res_idx hold stable. On res_ready → RUN (en=1) or IDLE (en=0), with accumulators cleared.
- en=0 in RUN/SYNC → IDLE next cycle; the partial window is discarded.
- en=0 in DONE → the result is still held until consumed.

## Timing
- All outputs registered except s_axis_tready, which decodes state.
- Reset values: res_valid 0, res_peak 0, res_idx 0, frame_err_cnt 0, busy 0, s_axis_tready 1.
- Final beat accepted at cycle N → res_valid=1 and DONE at N+1; tready=0 from N+1.
- Handshake at cycle M (res_valid & res_ready) → res_valid=0 and tready=1 at M+1. First beat of the next window can be accepted at M+1.
- Throughput: one beat per cycle in RUN. Dead time is exactly the DONE residency (minimum 1 cycle).
- En falls in the same cycle the final beat is accepted → abort; en wins and no result is produced.
- Framing error on the final beat → error path wins; no result.
- resetn low overrides everything, including mid-window and DONE; the result is lost.

## Configuration
- HYDRO_ARGMAX_EN defined: per-channel index registers and compare-index logic are built; res_idx behaves as above.
- HYDRO_ARGMAX_EN undefined: index registers are not built and res_idx ties to 0. Peak tracking and all timing are unchanged.

## Structure
- Package hydro_pkg:
  - Constants: CHANNELS=4, SAMPLE_W=16, ERR_W=8.
  - Types: sample_t (signed 16), mag_t (unsigned 16), win_state_e enum (IDLE, SYNC, RUN, DONE).
  - Saturating abs function.
- Sub-module peak_track:
  - One instance per channel via generate.
  - Inputs: clr, upd, sample, frame idx. Outputs: peak, idx.
  - The index port and register are inside the HYDRO_ARGMAX_EN guard.
- Top level holds the FSM, beat pointer, frame counter and error counter.

## Test plan
- WINDOW_FRAMES=4, en=1. Send 1 stray beat with tlast, then 4 frames. Ch0 values 10, −300, 300, 5 → res_peak ch0=300, idx=1 (tie at frame 2 ignored). res_valid appears 1 cycle after the 8th beat.
- Sample −32768 on ch3 → peak 32767.
- Hold res_ready=0 for 5 cycles → tready stays 0, outputs stable. Assert res_ready → tready=1 next cycle; the next window's peaks start at 0.
- Beat0 carrying tlast mid-window → frame_err_cnt=1, no res_valid; a full window then follows without a SYNC beat.
- Beat1 without tlast → error, return to SYNC; beats discarded until a tlast beat.
- Drop en in frame 3 → IDLE, no result. Drop en on the final beat → no result.
- Drop en while in DONE → result delivered, then IDLE.
- 300 framing errors → frame_err_cnt saturates at 255.
- Build without HYDRO_ARGMAX_EN → res_idx=0 and peaks are identical to the argmax build.
